// File: rtl/ram2e_pkg.sv
// Shared constants and types for the RAM2E C14M-domain DRAM/6502 timing generator.
package ram2e_pkg;

   localparam int unsigned S_W = 4;
   localparam int unsigned P_W = 5;

   localparam int unsigned REF_PERIOD_DEF = 13;
   localparam int unsigned PHI_NOM_DEF    = 14;
   localparam int unsigned PHI_LONG_DEF   = 16;

   localparam logic [S_W-1:0] S_IDLE     = 4'd0;
   localparam logic [S_W-1:0] S_START    = 4'd1;
   localparam logic [S_W-1:0] S_VDLAT    = 4'd3;
   localparam logic [S_W-1:0] S_REF      = 4'd4;
   localparam logic [S_W-1:0] S_C07XWIN  = 4'd7;
   localparam logic [S_W-1:0] S_C07XQUAL = 4'd8;
   localparam logic [S_W-1:0] S_BALAT    = 4'd10;
   localparam logic [S_W-1:0] S_MDLAT    = 4'd11;
   localparam logic [S_W-1:0] S_SAT      = 4'd15;

   localparam logic [P_W-1:0] P_MAX = 5'd31;

   typedef enum logic [1:0] {
      RASEL_ZERO = 2'b00,
      RASEL_HI   = 2'b01,
      RASEL_LO   = 2'b10
   } rasel_e;

   typedef struct packed {
      logic vdlat;
      logic c07xwin;
      logic c07xqual;
      logic balat;
      logic mdlat;
   } strobe_t;

endpackage

// File: rtl/ram2e_if.sv
// Bus between the timing generator (master) and the DRAM/bus logic it drives (slave).
interface ram2e_if;
   import ram2e_pkg::*;

   logic           PHI1;
   logic [S_W-1:0] S;
   logic           nRAS;
   logic           nCAS;
   logic [1:0]     RASEL;
   logic           MDBEN;
   logic           VDLAT;
   logic           C07XWIN;
   logic           C07XQUAL;
   logic           BALAT;
   logic           MDLAT;
   logic           REFCYC;
   logic           LOCK;
   logic           PERR;

   modport master (
      input  PHI1,
      output S, nRAS, nCAS, RASEL, MDBEN,
      output VDLAT, C07XWIN, C07XQUAL, BALAT, MDLAT,
      output REFCYC, LOCK, PERR
   );

   modport slave (
      output PHI1,
      input  S, nRAS, nCAS, RASEL, MDBEN,
      input  VDLAT, C07XWIN, C07XQUAL, BALAT, MDLAT,
      input  REFCYC, LOCK, PERR
   );

endinterface

// File: rtl/ram2e_phimon.sv
// PHI1 period monitor: measures C14M cycles between sync edges, reports lock and bad periods.
module ram2e_phimon
   import ram2e_pkg::*;
#(
   parameter int unsigned PHI_NOM  = PHI_NOM_DEF,
   parameter int unsigned PHI_LONG = PHI_LONG_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic se,
   output logic lock,
   output logic perr
);

   logic [P_W-1:0] p_q, p_d;
   logic           armed_q, armed_d;
   logic [1:0]     vcnt_q, vcnt_d;
   logic           lock_q, lock_d;
   logic           perr_q, perr_d;
   logic           period_ok;

   // The first sync edge only arms the measurement; later edges judge the elapsed period.
   always_comb begin
      p_d       = p_q;
      armed_d   = armed_q;
      vcnt_d    = vcnt_q;
      lock_d    = lock_q;
      perr_d    = 1'b0;
      period_ok = (p_q == P_W'(PHI_NOM)) || (p_q == P_W'(PHI_LONG));

      if (se) begin
         p_d     = P_W'(1);
         armed_d = 1'b1;
         if (armed_q) begin
            if (period_ok) begin
               if (vcnt_q != 2'd2) vcnt_d = vcnt_q + 2'd1;
               if (vcnt_q != 2'd0) lock_d = 1'b1;
            end else begin
               vcnt_d = 2'd0;
               lock_d = 1'b0;
               perr_d = 1'b1;
            end
         end
      end else if (p_q != P_MAX) begin
         p_d = p_q + P_W'(1);
      end

      // A period long enough to saturate the counter means PHI1 has stopped.
      if (!se && (p_d == P_MAX)) begin
         lock_d = 1'b0;
         vcnt_d = 2'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_q     <= '0;
         armed_q <= 1'b0;
         vcnt_q  <= 2'd0;
         lock_q  <= 1'b0;
         perr_q  <= 1'b0;
      end else begin
         p_q     <= p_d;
         armed_q <= armed_d;
         vcnt_q  <= vcnt_d;
         lock_q  <= lock_d;
         perr_q  <= perr_d;
      end
   end

   assign lock = lock_q;
   assign perr = perr_q;

endmodule

// File: rtl/ram2e_timing.sv
// C14M phase sequencer locked to PHI1: generates DRAM RAS/CAS, address mux select,
// bus gating, latch strobes and the refresh-skip schedule.
module ram2e_timing
   import ram2e_pkg::*;
#(
   parameter int unsigned REF_PERIOD = REF_PERIOD_DEF,
   parameter int unsigned PHI_NOM    = PHI_NOM_DEF,
   parameter int unsigned PHI_LONG   = PHI_LONG_DEF
) (
   input  logic     C14M,
   input  logic     nRST,
   ram2e_if.master  bus
);

   localparam int unsigned REF_W = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;

   logic             phi1_q, seen_q, se;
   logic [S_W-1:0]   s_q, s_d;
   logic [REF_W-1:0] ref_q, ref_d;
   logic             ras_n_q, ras_n_d;
   logic             cas_n_q, cas_n_d;
   logic             mdben_q, mdben_d;
   logic             refcyc_q, refcyc_d;
   rasel_e           rasel_q, rasel_d;
   strobe_t          stb_q, stb_d;
   logic             ref_slot;
   logic             lock, perr;

   // Rising PHI1 only counts once a low level has been seen since reset.
   assign se = bus.PHI1 & ~phi1_q & seen_q;

   always_comb begin
      s_d      = s_q;
      ref_d    = ref_q;
      ras_n_d  = 1'b1;
      cas_n_d  = 1'b1;
      rasel_d  = RASEL_ZERO;
      mdben_d  = 1'b0;
      stb_d    = '0;
      ref_slot = (s_q == S_REF) && (ref_q == '0);

      if (se)                  s_d = S_START;
      else if (s_q == S_IDLE)  s_d = S_IDLE;
      else if (s_q == S_SAT)   s_d = S_SAT;
      else                     s_d = s_q + S_W'(1);

      if (s_q == S_START)
         ref_d = (ref_q == REF_W'(REF_PERIOD - 1)) ? '0 : ref_q + REF_W'(1);

      ras_n_d = ~(se | (s_q inside {[S_START:4'd2]}) | ref_slot
                  | (s_q inside {[S_C07XWIN:S_BALAT]}));
      cas_n_d = ~((s_q inside {[4'd2:S_VDLAT]}) | ref_slot
                  | (s_q inside {[S_BALAT:S_MDLAT]}));

      if (s_q inside {[4'd6:S_C07XWIN]})          rasel_d = RASEL_HI;
      else if (s_q inside {[S_C07XQUAL:S_MDLAT]}) rasel_d = RASEL_LO;

      mdben_d        = (s_q >= S_BALAT);
      stb_d.vdlat    = (s_q == S_VDLAT);
      stb_d.c07xwin  = (s_q == S_C07XWIN);
      stb_d.c07xqual = (s_q == S_C07XQUAL);
      stb_d.balat    = (s_q == S_BALAT);
      stb_d.mdlat    = (s_q == S_MDLAT);
      refcyc_d       = (ref_d == '0);
   end

   always_ff @(posedge C14M or negedge nRST) begin
      if (!nRST) begin
         phi1_q   <= 1'b0;
         seen_q   <= 1'b0;
         s_q      <= S_IDLE;
         ref_q    <= '0;
         ras_n_q  <= 1'b1;
         cas_n_q  <= 1'b1;
         rasel_q  <= RASEL_ZERO;
         mdben_q  <= 1'b0;
         stb_q    <= '0;
         refcyc_q <= 1'b0;
      end else begin
         phi1_q   <= bus.PHI1;
         seen_q   <= seen_q | ~bus.PHI1;
         s_q      <= s_d;
         ref_q    <= ref_d;
         ras_n_q  <= ras_n_d;
         cas_n_q  <= cas_n_d;
         rasel_q  <= rasel_d;
         mdben_q  <= mdben_d;
         stb_q    <= stb_d;
         refcyc_q <= refcyc_d;
      end
   end

   ram2e_phimon #(
      .PHI_NOM  (PHI_NOM),
      .PHI_LONG (PHI_LONG)
   ) u_phimon (
      .clk   (C14M),
      .rst_n (nRST),
      .se    (se),
      .lock  (lock),
      .perr  (perr)
   );

   assign bus.S        = s_q;
   assign bus.nRAS     = ras_n_q;
   assign bus.nCAS     = cas_n_q;
   assign bus.RASEL    = rasel_q;
   assign bus.MDBEN    = mdben_q;
   assign bus.VDLAT    = stb_q.vdlat;
   assign bus.C07XWIN  = stb_q.c07xwin;
   assign bus.C07XQUAL = stb_q.c07xqual;
   assign bus.BALAT    = stb_q.balat;
   assign bus.MDLAT    = stb_q.mdlat;
   assign bus.REFCYC   = refcyc_q;
   assign bus.LOCK     = lock;
   assign bus.PERR     = perr;

endmodule

// File: doc/ram2e_timing.md
RAM2E_TIMING -- requirements
Module: ram2e_timing

Interface
REQ-001 SHALL provide parameter REF_PERIOD, default 13: refresh-skip modulus (one DRAM refresh per REF_PERIOD PHI1 phases).
REQ-002 SHALL provide parameter PHI_NOM, default 14: nominal 6502 cycle length in C14M cycles.
REQ-003 SHALL provide parameter PHI_LONG, default 16: stretched 6502 cycle length in C14M cycles.
REQ-004 C14M  input  1  14.318 MHz master clock; all state updates on rising edge.
REQ-005 nRST  input  1  asynchronous, active-low reset.
REQ-006 PHI1  input  1  Apple II PHI1, sampled directly on C14M.
REQ-007 S  output  4  phase state counter.
REQ-008 nRAS  output  1  registered DRAM RAS, active low.
REQ-009 nCAS  output  1  registered DRAM CAS, active low.
REQ-010 RASEL  output  2  RA[11:8] mux select: 01 = high bank bits, 10 = low bank bits, 00 = zero.
REQ-011 MDBEN  output  1  6502 data-bus gating enable.
REQ-012 VDLAT, C07XWIN, C07XQUAL, BALAT, MDLAT  output  1 each  one-cycle strobes (video latch, C073 window, C073 qualify, bank latch, read-data latch).
REQ-013 REFCYC  output  1  current PHI1 phase includes a refresh.
REQ-014 LOCK  output  1  PHI1 period tracking valid.
REQ-015 PERR  output  1  one-cycle pulse: bad PHI1 period measured.

Function
REQ-016 SHALL register PHI1 into PHI1reg each cycle; sync edge (SE) = PHI1 & ~PHI1reg & PHI0seen.
REQ-017 SHALL set PHI0seen on first cycle with PHI1 = 0; it stays set until reset.
REQ-018 S next: SE -> 1; else S = 0 -> 0; S = 15 -> 15 (saturate); else S+1.
REQ-019 Ref SHALL advance when S = 1, wrapping REF_PERIOD-1 -> 0; REFCYC = (Ref = 0).
REQ-020 nRAS next = ~(SE | S in {1,2} | (S = 4 & Ref = 0) | S in {7,8,9,10}).
REQ-021 nCAS next = ~(S in {2,3} | (S = 4 & Ref = 0) | S in {10,11}).
REQ-022 RASEL next: S in {6,7} -> 01; S in {8..11} -> 10; else 00.
REQ-023 MDBEN next = S in {10..15}.
REQ-024 Strobes registered from current S: VDLAT (S = 3), C07XWIN (S = 7), C07XQUAL (S = 8), BALAT (S = 10), MDLAT (S = 11); each exactly one cycle per phase.
REQ-025 Period counter P (5 bits): SE -> P := 1; else saturating increment to 31.
REQ-026 On SE with a prior SE since reset: period valid iff P in {PHI_NOM, PHI_LONG}; invalid -> PERR high next cycle for one cycle.
REQ-027 First SE after reset SHALL not measure and SHALL NOT raise PERR.
REQ-028 LOCK sets after two consecutive valid periods; clears on invalid period or when P reaches 31.
REQ-029 SE while S mid-sequence (short cycle) SHALL restart at S = 1 with no glitch beyond REQ-020..024 equations.
REQ-030 PHI1 held high: S saturates at 15, nRAS/nCAS high, MDBEN high, LOCK drops at P = 31.

Reset
REQ-031 nRST low: S = 0, Ref = 0, P = 0, PHI1reg = 0, PHI0seen = 0, measure-armed = 0, valid count = 0, nRAS = 1, nCAS = 1, RASEL = 00, MDBEN, all strobes, REFCYC-register, LOCK, PERR = 0.
REQ-032 Reset assertion mid-phase SHALL force outputs to reset values immediately; resumption requires PHI1 low then rising.

Structure
REQ-033 Shared package ram2e_pkg: state code constants (S_IDLE = 0, S_SAT = 15, latch states 3/7/8/10/11), RASEL encodings, default period constants.
REQ-034 One sub-module natural: ram2e_phimon (P counter, period check, LOCK/PERR); all else flat.

Verification
REQ-035 Reset, PHI1 high 20 cycles -> S = 0, nRAS = nCAS = 1, no strobes.
REQ-036 PHI1 low 7 / high 7 repeating -> after 2nd SE, S = 1..7 sequence; nRAS low at S-states 2,3 and 8..11 (registered); LOCK = 1 after 3rd SE; PERR never.
REQ-037 13 consecutive phases -> refresh CAS (S = 4 term) in exactly one phase, Ref wraps 12 -> 0.
REQ-038 One 16-cycle stretched period inserted -> no PERR, LOCK stays 1; one 12-cycle period -> PERR pulse one cycle, LOCK = 0, relocks after two good periods.
REQ-039 PHI1 stuck high 40 cycles -> S = 15, MDBEN = 1, LOCK = 0 once P = 31.
REQ-040 nRST asserted at S = 9 -> all outputs reset values same cycle; recovery needs PHI1 low then high.
